// File: rtl/ahb_uart_debug_master_if.sv
// ahb_bus_if: single-layer AHB-Lite bus bundle.
//   master modport: drives haddr, hwrite, hsize, htrans, hwdata;
//                   samples hready, hresp, hrdata.
//   slave modport : the mirror image, for bus-side models and slaves.
interface ahb_bus_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output haddr, hwrite, hsize, htrans, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, hsize, htrans, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_uart_debug_master.sv
// ahb_uart_debug_master: UART-to-AHB-Lite debug bridge.
// The host sends framed commands on rxd. The bridge issues one single-word
// AHB-Lite transfer per command and answers on txd.
//   Write: 57 A0..A3 D0..D3      -> 06 | 15
//   Read : 52 A0..A3             -> 06 D0..D3 | 15
// Ports:
//   clk   system clock
//   nrst  synchronous active-low reset
//   rxd   UART serial in from host
//   txd   UART serial out to host
//   abif  AHB-Lite master port (ahb_bus_if.master)
//   busy  high whenever the command FSM is not in IDLE
// The file also holds uart_rx and uart_tx, the byte-level UART engines.

// uart_rx: 8N1 receiver. It samples each bit at mid-period and pulses
// rx_done for one cycle with rx_data valid.
//   clk, nrst   clock / synchronous active-low reset
//   bit_period  clk cycles per bit
//   rxd         serial input (asynchronous, synchronised here)
//   rx_data     received byte
//   rx_done     one-cycle strobe per good frame
module uart_rx (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] bit_period,
    input  logic        rxd,
    output logic [7:0]  rx_data,
    output logic        rx_done
);
    logic [1:0]  sync;
    logic        active;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_idx;
    logic [7:0]  shreg;
    logic        rxd_s;
    logic [15:0] half;

    assign rxd_s = sync[1];
    assign half  = bit_period >> 1;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync     <= 2'b11;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            sync    <= {sync[0], rxd};
            rx_done <= 1'b0;
            if (!active) begin
                if (!rxd_s) begin
                    active   <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            end else begin
                baud_cnt <= (baud_cnt == bit_period - 16'd1) ? '0 : baud_cnt + 16'd1;
                if (baud_cnt == half) begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd0) begin
                        // Start bit gone high again by mid-bit: a glitch.
                        if (rxd_s) active <= 1'b0;
                    end else if (bit_idx == 4'd9) begin
                        // Return to idle at mid stop bit so the next start
                        // edge is seen; frames with a bad stop bit are dropped.
                        active <= 1'b0;
                        if (rxd_s) begin
                            rx_data <= shreg;
                            rx_done <= 1'b1;
                        end
                    end else begin
                        shreg <= {rxd_s, shreg[7:1]};
                    end
                end
            end
        end
    end
endmodule

// uart_tx: 8N1 transmitter.
//   clk, nrst   clock / synchronous active-low reset
//   bit_period  clk cycles per bit
//   tx_start    request; accepted only while tx_busy is low
//   tx_data     byte to send, sampled on acceptance
//   tx_busy     high from the cycle after acceptance until the stop bit ends
//   tx_done     one-cycle strobe at the end of the stop bit
//   txd         serial output, idles high
module uart_tx (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] bit_period,
    input  logic        tx_start,
    input  logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        txd
);
    logic [9:0]  shreg;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_idx;

    assign txd = shreg[0];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            shreg    <= '1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (tx_start) begin
                    shreg    <= {1'b1, tx_data, 1'b0};
                    tx_busy  <= 1'b1;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                end
            end else if (baud_cnt == bit_period - 16'd1) begin
                baud_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                    shreg   <= '1;
                end else begin
                    shreg   <= {1'b1, shreg[9:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end
endmodule

module ahb_uart_debug_master #(
    parameter logic [15:0] BIT_PERIOD     = 16'd868,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          rxd,
    output logic          txd,
    ahb_bus_if.master     abif,
    output logic          busy
);
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        BUS_ADDR,
        BUS_DATA,
        TX_RESP
    } state_t;

    state_t state, state_next;

    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;

    logic        op_write;
    logic [1:0]  byte_cnt;
    logic [31:0] idle_cnt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bus_err;
    logic        resp_nak;
    logic [2:0]  tx_idx;
    logic        tx_sent;

    logic [31:0] addr_shift;
    logic [31:0] wdata_shift;
    logic        last_byte;
    logic        timed_out;
    logic        valid_op;
    logic [2:0]  tx_last_idx;
    logic        tx_last;

    uart_rx u_rx (
        .clk        (clk),
        .nrst       (nrst),
        .bit_period (BIT_PERIOD),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_done    (rx_done)
    );

    uart_tx u_tx (
        .clk        (clk),
        .nrst       (nrst),
        .bit_period (BIT_PERIOD),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .txd        (txd)
    );

    // Fields arrive little-endian: each new byte enters at the top.
    assign addr_shift  = {rx_data, addr[31:8]};
    assign wdata_shift = {rx_data, wdata[31:8]};
    assign last_byte   = (byte_cnt == 2'd3);
    assign timed_out   = (idle_cnt >= TIMEOUT_CYCLES);
    assign valid_op    = (rx_data == OP_WRITE) || (rx_data == OP_READ);
    assign tx_last_idx = (!op_write && !resp_nak) ? 3'd4 : 3'd0;
    assign tx_last     = (tx_idx == tx_last_idx);

    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        abif.htrans  = HTRANS_IDLE;
        abif.haddr   = '0;
        abif.hwrite  = 1'b0;
        abif.hsize   = '0;
        abif.hwdata  = '0;
        tx_start     = 1'b0;
        busy         = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (rx_done && valid_op) state_next = RX_ADDR;
            end
            RX_ADDR: begin
                if (rx_done) begin
                    if (last_byte) begin
                        if (addr_shift[1:0] != 2'b00) state_next = TX_RESP;
                        else if (op_write)            state_next = RX_DATA;
                        else                          state_next = BUS_ADDR;
                    end
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            RX_DATA: begin
                if (rx_done) begin
                    if (last_byte) state_next = BUS_ADDR;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            BUS_ADDR: begin
                abif.htrans = HTRANS_NONSEQ;
                abif.haddr  = addr;
                abif.hwrite = op_write;
                abif.hsize  = HSIZE_WORD;
                if (abif.hready) state_next = BUS_DATA;
            end
            BUS_DATA: begin
                if (op_write) abif.hwdata = wdata;
                if (abif.hready) state_next = TX_RESP;
            end
            TX_RESP: begin
                tx_start = !tx_sent;
                if (tx_sent && tx_done && tx_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_data = '0;
        case (tx_idx)
            3'd0:    tx_data = resp_nak ? RSP_NAK : RSP_ACK;
            3'd1:    tx_data = rdata[7:0];
            3'd2:    tx_data = rdata[15:8];
            3'd3:    tx_data = rdata[23:16];
            3'd4:    tx_data = rdata[31:24];
            default: tx_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            op_write <= 1'b0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
            bus_err  <= 1'b0;
            resp_nak <= 1'b0;
            tx_idx   <= '0;
            tx_sent  <= 1'b0;
        end else begin
            if (state != TX_RESP) begin
                tx_idx  <= '0;
                tx_sent <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rx_done && valid_op) begin
                        op_write <= (rx_data == OP_WRITE);
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                        bus_err  <= 1'b0;
                        resp_nak <= 1'b0;
                    end
                end
                RX_ADDR, RX_DATA: begin
                    if (rx_done) begin
                        // byte_cnt wraps 3->0, so RX_DATA starts counting afresh.
                        byte_cnt <= byte_cnt + 2'd1;
                        idle_cnt <= '0;
                        if (state == RX_ADDR) begin
                            addr <= addr_shift;
                            if (last_byte && (addr_shift[1:0] != 2'b00)) resp_nak <= 1'b1;
                        end else begin
                            wdata <= wdata_shift;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                BUS_DATA: begin
                    if (abif.hresp) bus_err <= 1'b1;
                    if (abif.hready) begin
                        if (!op_write) rdata <= abif.hrdata;
                        resp_nak <= bus_err | abif.hresp;
                    end
                end
                TX_RESP: begin
                    // tx_start is held until uart_tx reports busy, then the
                    // byte is counted as sent once tx_done arrives.
                    if (!tx_sent) begin
                        if (tx_busy) tx_sent <= 1'b1;
                    end else if (tx_done) begin
                        tx_sent <= 1'b0;
                        tx_idx  <= tx_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_uart_debug_master.sv
module tb_ahb_uart_debug_master;
    localparam int unsigned BP = 8;
    localparam int unsigned TO = 400;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic rxd = 1'b1;
    logic txd;
    logic busy;

    ahb_bus_if bus ();

    ahb_uart_debug_master #(
        .BIT_PERIOD     (16'(BP)),
        .TIMEOUT_CYCLES (32'(TO))
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .rxd  (rxd),
        .txd  (txd),
        .abif (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Slave contents for addresses never written.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- bus slave + monitor ----------------
    logic [31:0] slave_mem [logic [31:0]];
    int          nonseq_cnt = 0;
    int          proto_err  = 0;
    int          cfg_wait   = 0;
    bit          cfg_err    = 0;
    logic [31:0] ap_addr;
    logic        ap_write;
    logic [2:0]  ap_hsize;
    logic [31:0] last_wdata;
    bit          dp_active  = 0;
    bit          dp_first;
    bit          dp_err;
    bit          dp_write;
    int          dp_wait;
    logic [31:0] dp_addr;
    logic [31:0] dp_wdata0;

    initial begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                dp_active  = 0;
                bus.hready = 1'b1;
                bus.hresp  = 1'b0;
                continue;
            end
            if (bus.htrans == 2'b01 || bus.htrans == 2'b11) proto_err++;
            if (dp_active) begin
                if (bus.htrans != 2'b00) proto_err++;
                if (dp_write) begin
                    if (dp_first) dp_wdata0 = bus.hwdata;
                    else if (bus.hwdata !== dp_wdata0) proto_err++;
                end
                dp_first = 0;
                if (dp_wait > 0) begin
                    bus.hready = 1'b0;
                    bus.hresp  = dp_err && (dp_wait == 1);
                    bus.hrdata = $urandom;
                    dp_wait--;
                end else begin
                    bus.hready = 1'b1;
                    bus.hresp  = dp_err;
                    if (dp_write) begin
                        bus.hrdata = $urandom;
                        last_wdata = bus.hwdata;
                        if (!dp_err) slave_mem[dp_addr] = bus.hwdata;
                    end else begin
                        bus.hrdata = slave_mem.exists(dp_addr) ? slave_mem[dp_addr] : dflt(dp_addr);
                    end
                    dp_active = 0;
                end
            end else begin
                bus.hresp  = 1'b0;
                bus.hrdata = $urandom;
                bus.hready = ($urandom_range(0, 3) != 0);
                if (bus.htrans == 2'b10 && bus.hready) begin
                    nonseq_cnt++;
                    ap_addr   = bus.haddr;
                    ap_write  = bus.hwrite;
                    ap_hsize  = bus.hsize;
                    dp_active = 1;
                    dp_first  = 1;
                    dp_wait   = cfg_wait;
                    dp_err    = cfg_err;
                    dp_addr   = bus.haddr;
                    dp_write  = bus.hwrite;
                end
            end
        end
    end

    // ---------------- host UART side ----------------
    logic [7:0] resp_q [$];

    initial begin : txd_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (nrst && txd == 1'b0) begin
                repeat (BP / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BP) @(negedge clk);
                    b[i] = txd;
                end
                repeat (BP) @(negedge clk);
                resp_q.push_back(b);
            end
        end
    end

    task automatic uart_send(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            repeat (BP) @(negedge clk);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] model_mem [logic [31:0]];

    task automatic run_cmd(input bit is_write, input logic [31:0] a, input logic [31:0] d,
                           input int waits, input bit err, input string tag);
        logic [7:0]  exp_resp [$];
        logic [31:0] rv;
        int          exp_ns;
        int          ns0;
        int          n;
        cfg_wait = waits;
        cfg_err  = err;
        ns0      = nonseq_cnt;
        resp_q.delete();

        if (a[1:0] != 2'b00) begin
            exp_resp = '{8'h15};
            exp_ns   = 0;
        end else if (err) begin
            exp_resp = '{8'h15};
            exp_ns   = 1;
        end else if (is_write) begin
            exp_resp = '{8'h06};
            exp_ns   = 1;
            model_mem[a] = d;
        end else begin
            rv = model_mem.exists(a) ? model_mem[a] : dflt(a);
            exp_resp = '{8'h06, rv[7:0], rv[15:8], rv[23:16], rv[31:24]};
            exp_ns   = 1;
        end

        uart_send(is_write ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) uart_send(8'(a >> (8 * i)));
        if (is_write) for (int i = 0; i < 4; i++) uart_send(8'(d >> (8 * i)));

        n = 0;
        while ((busy || resp_q.size() < exp_resp.size()) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ":idle"}, 32'(busy), 32'd0);
        repeat (3 * BP) @(negedge clk);

        check_eq({tag, ":resp_len"}, resp_q.size(), exp_resp.size());
        for (int i = 0; i < exp_resp.size(); i++)
            check_eq($sformatf("%s:byte%0d", tag, i),
                     (i < resp_q.size()) ? 32'(resp_q[i]) : 32'hFFFF_FFFF, 32'(exp_resp[i]));
        check_eq({tag, ":nonseq"}, nonseq_cnt - ns0, exp_ns);
        if (exp_ns == 1) begin
            check_eq({tag, ":haddr"}, ap_addr, a);
            check_eq({tag, ":hwrite"}, 32'(ap_write), 32'(is_write));
            check_eq({tag, ":hsize"}, 32'(ap_hsize), 32'd2);
            if (is_write) check_eq({tag, ":hwdata"}, last_wdata, d);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ns0;
        int n;
        logic [31:0] a;
        repeat (4) @(negedge clk);
        check_eq("rst:busy", 32'(busy), 32'd0);
        check_eq("rst:txd", 32'(txd), 32'd1);
        check_eq("rst:htrans", 32'(bus.htrans), 32'd0);
        check_eq("rst:haddr", bus.haddr, 32'd0);
        check_eq("rst:hwrite", 32'(bus.hwrite), 32'd0);
        check_eq("rst:hsize", 32'(bus.hsize), 32'd0);
        check_eq("rst:hwdata", bus.hwdata, 32'd0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        run_cmd(1, 32'h0002_0000, 32'h1122_3344, 0, 0, "write_ok");

        slave_mem[32'h0002_0008] = 32'h0000_00A5;
        model_mem[32'h0002_0008] = 32'h0000_00A5;
        run_cmd(0, 32'h0002_0008, 32'h0, 3, 0, "read_wait");

        run_cmd(0, 32'h0002_0010, 32'h0, 1, 1, "bus_err");
        run_cmd(1, 32'h0002_0014, 32'hCAFE_F00D, 0, 1, "wr_err_zw");
        run_cmd(0, 32'h0000_0001, 32'h0, 0, 0, "misaligned");

        // Garbage byte, then a truncated write left to time out.
        ns0 = nonseq_cnt;
        resp_q.delete();
        uart_send(8'hFF);
        repeat (2) @(negedge clk);
        check_eq("garbage:busy", 32'(busy), 32'd0);
        uart_send(8'h57);
        uart_send(8'h00);
        uart_send(8'h00);
        check_eq("partial:busy", 32'(busy), 32'd1);
        repeat (TO + 2 * BP) @(negedge clk);
        check_eq("timeout:busy", 32'(busy), 32'd0);
        check_eq("timeout:nonseq", nonseq_cnt - ns0, 0);
        check_eq("timeout:resp", resp_q.size(), 0);
        run_cmd(0, 32'h0002_0000, 32'h0, 1, 0, "after_timeout");

        // Reset while the data phase is stalled.
        cfg_wait = 40;
        cfg_err  = 0;
        uart_send(8'h52);
        for (int i = 0; i < 4; i++) uart_send(8'(32'h0002_0004 >> (8 * i)));
        n = 0;
        while (!dp_active && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstmid:in_data_phase", 32'(dp_active), 32'd1);
        nrst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rstmid:htrans", 32'(bus.htrans), 32'd0);
        check_eq("rstmid:busy", 32'(busy), 32'd0);
        check_eq("rstmid:txd", 32'(txd), 32'd1);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        resp_q.delete();

        // Randomised commands over a small window so reads revisit writes.
        for (int k = 0; k < 28; k++) begin
            a = 32'h0002_0000 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            run_cmd($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 4),
                    $urandom_range(0, 5) == 0, $sformatf("rand%0d", k));
        end

        check_eq("bus_protocol", proto_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
